// File: rtl/ucie_sb_pkg.sv
// Shared types and protocol constants for the UCIe sideband TX path.
package ucie_sb_pkg;

  localparam int unsigned SB_PHASE_W    = 64;
  localparam int unsigned SB_MIN_GAP_UI = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR,
    ST_GAP_H,
    ST_DATA,
    ST_GAP_D
  } sb_tx_state_e;

endpackage

// File: rtl/ucie_sb_rr_arbiter.sv
// Combinational round-robin pick; the pointer (last winner) is owned by the caller.
module ucie_sb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_any_req
);

  always_comb begin
    int unsigned w_idx;
    o_grant   = '0;
    o_any_req = 1'b0;
    w_idx     = 0;
    // Scan starts one slot past the last winner, so the last winner has lowest priority.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_any_req && i_req_valid[w_idx[IDX_W-1:0]]) begin
        o_grant   = w_idx[IDX_W-1:0];
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ucie_sb_tx_scheduler.sv
// Arbitrates sideband packet sources onto the single serial TX lane:
// header phase, optional data phase, each followed by a mandatory idle gap.
module ucie_sb_tx_scheduler
  import ucie_sb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PKT_W   = SB_PHASE_W,
  parameter int unsigned GAP_UI  = SB_MIN_GAP_UI
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_has_data,
  input  logic [NUM_REQ*PKT_W-1:0]     req_hdr,
  input  logic [NUM_REQ*PKT_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         SBTX_DATA,
  output logic                         SBTX_CLK_EN,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = $clog2(GAP_UI + 1);

  sb_tx_state_e       r_state;
  sb_tx_state_e       w_next_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [PKT_W-1:0]   r_shift;
  logic [PKT_W-1:0]   r_data;
  logic               r_has_data;
  logic [5:0]         r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_sbtx_data;
  logic               r_clk_en;

  logic [IDX_W-1:0]   w_arb_grant;
  logic               w_arb_any;
  logic [PKT_W-1:0]   w_sel_hdr;
  logic [PKT_W-1:0]   w_sel_data;
  logic               w_phase_last;
  logic               w_gap_done;

  ucie_sb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req_valid (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_arb_grant),
    .o_any_req   (w_arb_any)
  );

  assign w_sel_hdr    = req_hdr[32'(r_grant)*PKT_W +: PKT_W];
  assign w_sel_data   = req_data[32'(r_grant)*PKT_W +: PKT_W];
  assign w_phase_last = (r_bit_cnt == 6'(PKT_W - 1));
  assign w_gap_done   = (r_gap_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    busy         = (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE:  if (tx_enable && w_arb_any) w_next_state = ST_LOAD;
      ST_LOAD: begin
        req_ready[r_grant] = 1'b1;
        w_next_state       = ST_HDR;
      end
      ST_HDR:   if (w_phase_last) w_next_state = ST_GAP_H;
      ST_GAP_H: if (w_gap_done) w_next_state = r_has_data ? ST_DATA : ST_IDLE;
      ST_DATA:  if (w_phase_last) w_next_state = ST_GAP_D;
      ST_GAP_D: if (w_gap_done) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Lane registers are loaded with the bit for the state being entered, so
  // SBTX_CLK_EN is high exactly while the state register holds HDR or DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_grant     <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_has_data  <= 1'b0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_sbtx_data <= 1'b0;
      r_clk_en    <= 1'b0;
    end else begin
      r_clk_en <= (w_next_state == ST_HDR) || (w_next_state == ST_DATA);
      unique case (r_state)
        ST_IDLE: begin
          if (w_next_state == ST_LOAD) begin
            r_grant <= w_arb_grant;
            r_ptr   <= w_arb_grant;
          end
        end
        ST_LOAD: begin
          r_shift     <= w_sel_hdr >> 1;
          r_sbtx_data <= w_sel_hdr[0];
          r_data      <= w_sel_data;
          r_has_data  <= req_has_data[r_grant];
          r_bit_cnt   <= '0;
        end
        ST_HDR, ST_DATA: begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_phase_last) begin
            r_sbtx_data <= 1'b0;
            r_gap_cnt   <= GAP_W'(GAP_UI - 1);
          end else begin
            r_sbtx_data <= r_shift[0];
            r_shift     <= r_shift >> 1;
          end
        end
        ST_GAP_H, ST_GAP_D: begin
          if (!w_gap_done) r_gap_cnt <= r_gap_cnt - 1'b1;
          if (w_next_state == ST_DATA) begin
            r_shift     <= r_data >> 1;
            r_sbtx_data <= r_data[0];
            r_bit_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign SBTX_DATA   = r_sbtx_data;
  assign SBTX_CLK_EN = r_clk_en;
  assign grant_id    = r_grant;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_clk_en_phase: assert property (@(posedge clk)
    SBTX_CLK_EN |-> (r_state == ST_HDR || r_state == ST_DATA));

endmodule

// File: tb/tb_ucie_sb_tx_scheduler.sv
// Bench for the sideband TX scheduler: vector table, directed sequences and
// randomized packet mixes scored against a packet-level round-robin model.
module tb_ucie_sb_tx_scheduler;

  localparam int NR     = 4;
  localparam int PW     = 64;
  localparam int GAP    = 32;
  localparam int MAXC   = 20000;
  localparam int ROUNDS = 12;

  logic                 clk;
  logic                 reset;
  logic                 tx_enable;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_has_data;
  logic [NR*PW-1:0]     req_hdr;
  logic [NR*PW-1:0]     req_data;
  logic [NR-1:0]        req_ready;
  logic                 SBTX_DATA;
  logic                 SBTX_CLK_EN;
  logic                 busy;
  logic [$clog2(NR)-1:0] grant_id;

  ucie_sb_tx_scheduler #(
    .NUM_REQ (NR),
    .PKT_W   (PW),
    .GAP_UI  (GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_enable    (tx_enable),
    .req_valid    (req_valid),
    .req_has_data (req_has_data),
    .req_hdr      (req_hdr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .SBTX_DATA    (SBTX_DATA),
    .SBTX_CLK_EN  (SBTX_CLK_EN),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endfunction

  function automatic void check_ge(input string name, input int act, input int lim);
    total++;
    if (act < lim) begin
      bad++;
      $display("FAIL %s: got=%0d want>=%0d", name, act, lim);
    end
  endfunction

  // Per-cycle logs sampled on the falling edge.
  logic          en_log  [MAXC];
  logic          dat_log [MAXC];
  logic          busy_log[MAXC];
  logic [NR-1:0] rdy_log [MAXC];
  logic [1:0]    gid_log [MAXC];

  logic [63:0] words[$];
  int          rdy_q[$];
  int          rdy_cyc[$];
  int          bad_runs, min_gap, multi_rdy, gid_bad;

  task automatic log_cycle(input int c);
    en_log[c]   = SBTX_CLK_EN;
    dat_log[c]  = SBTX_DATA;
    busy_log[c] = busy;
    rdy_log[c]  = req_ready;
    gid_log[c]  = grant_id;
  endtask

  // Turn the logged lane into 64-bit words and idle-run statistics.
  task automatic analyze(input int n);
    int          run1, run0, idx;
    bit          seen1;
    logic [63:0] acc;
    words.delete(); rdy_q.delete(); rdy_cyc.delete();
    bad_runs = 0; min_gap = 1 << 30; multi_rdy = 0; gid_bad = 0;
    run1 = 0; run0 = 0; seen1 = 0; acc = '0;
    for (int c = 0; c < n; c++) begin
      if (en_log[c]) begin
        if (run0 > 0 && seen1 && run0 < min_gap) min_gap = run0;
        if (run1 < 64) acc[6'(run1)] = dat_log[c];
        run1++;
        run0 = 0;
      end else begin
        if (run1 > 0) begin
          if (run1 == 64) words.push_back(acc);
          else bad_runs++;
          seen1 = 1;
        end
        run1 = 0;
        run0++;
      end
      if (rdy_log[c] != '0) begin
        if (!$onehot(rdy_log[c])) multi_rdy++;
        idx = 0;
        for (int i = NR - 1; i >= 0; i--) if (rdy_log[c][i]) idx = i;
        rdy_q.push_back(idx);
        rdy_cyc.push_back(c);
        if (int'(gid_log[c]) != idx) gid_bad++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tx_enable = 1'b0; req_valid = '0; req_has_data = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Cycle 0 is the cycle in which the caller drove the inputs.
  task automatic run_seq(input int n, input int tx_off, input int tx_on,
                         input int rst_at, input logic [NR-1:0] rst_valid, input bit drop);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      log_cycle(c);
      @(posedge clk); #1;
      if (drop) req_valid = req_valid & ~rdy_log[c];
      if (c + 1 == tx_off) tx_enable = 1'b0;
      if (c + 1 == tx_on)  tx_enable = 1'b1;
      reset = (c + 1 == rst_at);
      if (c + 1 == rst_at) req_valid = rst_valid;
    end
  endtask

  function automatic logic [63:0] hdr_of(input int i);
    logic [NR*PW-1:0] t;
    t = req_hdr;
    return t[i*PW +: PW];
  endfunction

  task automatic rand_hdrs();
    for (int i = 0; i < NR; i++) begin
      req_hdr[i*PW +: PW]  = {$urandom(), $urandom()};
      req_data[i*PW +: PW] = {$urandom(), $urandom()};
    end
  endtask

  typedef struct {
    logic          txe;
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_rdy;
    logic [1:0]    exp_gid;
    logic          exp_go;
  } vec_t;

  typedef struct {
    logic [63:0] h;
    logic [63:0] d;
    logic        hd;
  } pkt_t;

  pkt_t q[NR][$];

  task automatic drive_heads();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (q[i].size() != 0);
      if (q[i].size() != 0) begin
        req_hdr[i*PW +: PW]  = q[i][0].h;
        req_data[i*PW +: PW] = q[i][0].d;
        req_has_data[i]      = q[i][0].hd;
      end
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (q[i].size() != 0) return 0;
    return 1;
  endfunction

  initial begin
    vec_t        vecs[7];
    logic [63:0] h, d, e;
    int          model_ptr, nc, idx, pos[NR];
    bit          done, found;
    logic [63:0] exp_words[$];
    int          exp_ids[$];

    vecs[0] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vecs[2] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[3] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[4] = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1};
    vecs[5] = '{1'b1, 4'b1100, 4'b0100, 2'd2, 1'b1};
    vecs[6] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};

    req_hdr = '0; req_data = '0;
    do_reset();
    @(negedge clk);
    check("rst_data",  64'(SBTX_DATA), 64'd0);
    check("rst_clken", 64'(SBTX_CLK_EN), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_gid",   64'(grant_id), 64'd0);
    @(posedge clk); #1;

    // Vector table: first arbitration decision out of reset.
    foreach (vecs[v]) begin
      do_reset();
      rand_hdrs();
      tx_enable = vecs[v].txe; req_valid = vecs[v].valid; req_has_data = '0;
      run_seq(4, -1, -1, -1, '0, 1'b1);
      h = hdr_of(int'(vecs[v].exp_gid));
      check($sformatf("vec%0d_rdy0", v), 64'(rdy_log[0]), 64'd0);
      check($sformatf("vec%0d_rdy1", v), 64'(rdy_log[1]), 64'(vecs[v].exp_rdy));
      check($sformatf("vec%0d_gid", v),  64'(gid_log[1]), 64'(vecs[v].exp_gid));
      check($sformatf("vec%0d_busy", v), 64'(busy_log[1]), 64'(vecs[v].exp_go));
      check($sformatf("vec%0d_en2", v),  64'(en_log[2]), 64'(vecs[v].exp_go));
      check($sformatf("vec%0d_bit0", v), 64'(dat_log[2]), vecs[v].exp_go ? 64'(h[0]) : 64'd0);
    end

    // Single header-only packet from req0.
    do_reset();
    req_hdr[0 +: PW] = 64'hA5A5_0000_FFFF_1234;
    tx_enable = 1'b1; req_valid = 4'b0001; req_has_data = '0;
    run_seq(110, -1, -1, -1, '0, 1'b1);
    analyze(110);
    check("single_nwords", 64'(words.size()), 64'd1);
    if (words.size() > 0) check("single_hdr", words[0], 64'hA5A5_0000_FFFF_1234);
    check("single_nrdy", 64'(rdy_q.size()), 64'd1);
    if (rdy_cyc.size() > 0) check("single_rdy_cyc", 64'(rdy_cyc[0]), 64'd1);
    check("single_en1",   64'(en_log[1]), 64'd0);
    check("single_en2",   64'(en_log[2]), 64'd1);
    check("single_en65",  64'(en_log[65]), 64'd1);
    check("single_en66",  64'(en_log[66]), 64'd0);
    check("single_busy97", 64'(busy_log[97]), 64'd1);
    check("single_busy98", 64'(busy_log[98]), 64'd0);

    // Header + data packet from req2, data = 1.
    do_reset();
    rand_hdrs();
    req_data[2*PW +: PW] = 64'h1;
    h = hdr_of(2);
    tx_enable = 1'b1; req_valid = 4'b0100; req_has_data = 4'b0100;
    run_seq(200, -1, -1, -1, '0, 1'b1);
    analyze(200);
    check("hd_nwords", 64'(words.size()), 64'd2);
    if (words.size() > 1) begin
      check("hd_hdr",  words[0], h);
      check("hd_data", words[1], 64'h1);
    end
    if (rdy_q.size() > 0) check("hd_gid", 64'(rdy_q[0]), 64'd2);
    check("hd_gap_exact", 64'(min_gap), 64'(GAP));
    check("hd_en97",  64'(en_log[97]), 64'd0);
    check("hd_en98",  64'(en_log[98]), 64'd1);
    check("hd_bit0",  64'(dat_log[98]), 64'd1);
    check("hd_busy193", 64'(busy_log[193]), 64'd1);
    check("hd_busy194", 64'(busy_log[194]), 64'd0);

    // Round robin with all four requesters continuously valid.
    do_reset();
    rand_hdrs();
    tx_enable = 1'b1; req_valid = 4'b1111; req_has_data = '0;
    run_seq(400, -1, -1, -1, '0, 1'b0);
    analyze(400);
    check("rr_nrdy", 64'(rdy_q.size()), 64'd5);
    for (int k = 0; k < 5 && k < rdy_q.size(); k++) begin
      check($sformatf("rr_order%0d", k), 64'(rdy_q[k]), 64'(k % NR));
      check($sformatf("rr_cyc%0d", k), 64'(rdy_cyc[k]), 64'(1 + 98 * k));
    end
    check("rr_nwords", 64'(words.size()), 64'd4);
    for (int k = 0; k < 4 && k < words.size(); k++)
      check($sformatf("rr_word%0d", k), words[k], hdr_of(k));
    check_ge("rr_spacing", min_gap, GAP + 2);

    // tx_enable dropped at bit 10 of req1 header, restored later.
    do_reset();
    rand_hdrs();
    tx_enable = 1'b1; req_valid = 4'b0110; req_has_data = '0;
    run_seq(270, 12, 200, -1, '0, 1'b0);
    analyze(270);
    check("txe_nrdy", 64'(rdy_q.size()), 64'd2);
    if (rdy_q.size() > 1) begin
      check("txe_first",  64'(rdy_q[0]), 64'd1);
      check("txe_second", 64'(rdy_q[1]), 64'd2);
      check("txe_resume_cyc", 64'(rdy_cyc[1]), 64'd201);
    end
    check("txe_en65", 64'(en_log[65]), 64'd1);
    check("txe_nwords", 64'(words.size()), 64'd2);
    if (words.size() > 1) begin
      check("txe_word0", words[0], hdr_of(1));
      check("txe_word1", words[1], hdr_of(2));
    end
    check("txe_idle_busy", 64'(busy_log[150]), 64'd0);

    // Reset at bit 30 of req2's data phase.
    do_reset();
    rand_hdrs();
    d = req_data[2*PW +: PW];
    tx_enable = 1'b1; req_valid = 4'b0100; req_has_data = 4'b0100;
    run_seq(140, -1, -1, 128, 4'b1111, 1'b1);
    check("rst_mid_en128",  64'(en_log[128]), 64'd1);
    check("rst_mid_bit30",  64'(dat_log[128]), 64'(d[30]));
    check("rst_mid_en129",  64'(en_log[129]), 64'd0);
    check("rst_mid_busy129", 64'(busy_log[129]), 64'd0);
    check("rst_mid_gid129", 64'(gid_log[129]), 64'd0);
    check("rst_mid_rdy130", 64'(rdy_log[130]), 64'b0001);
    check("rst_mid_en132",  64'(en_log[132]), 64'd1);

    // Randomized packet mixes against a packet-level round-robin model.
    do_reset();
    model_ptr = NR - 1;
    tx_enable = 1'b1;
    for (int r = 0; r < ROUNDS; r++) begin
      pkt_t p;
      exp_words.delete(); exp_ids.delete();
      for (int i = 0; i < NR; i++) begin
        int n;
        n = $urandom_range(0, 4);
        for (int j = 0; j < n; j++) begin
          p.h  = {$urandom(), $urandom()};
          p.d  = {$urandom(), $urandom()};
          p.hd = 1'($urandom_range(0, 1));
          q[i].push_back(p);
        end
        pos[i] = 0;
      end
      found = 1;
      while (found) begin
        found = 0;
        for (int k = 1; k <= NR && !found; k++) begin
          idx = (model_ptr + k) % NR;
          if (pos[idx] < q[idx].size()) begin
            found = 1;
            exp_ids.push_back(idx);
            exp_words.push_back(q[idx][pos[idx]].h);
            if (q[idx][pos[idx]].hd) exp_words.push_back(q[idx][pos[idx]].d);
            pos[idx]++;
            model_ptr = idx;
          end
        end
      end

      drive_heads();
      nc = 0; done = 0;
      while (!done && nc < MAXC) begin
        @(negedge clk);
        log_cycle(nc);
        if (all_empty() && !busy) done = 1;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) if (rdy_log[nc][i] && q[i].size() != 0) void'(q[i].pop_front());
        if ($urandom_range(0, 99) == 0) tx_enable = ~tx_enable;
        drive_heads();
        nc++;
      end
      check($sformatf("rnd%0d_done", r), 64'(done), 64'd1);
      analyze(nc);
      check($sformatf("rnd%0d_nrdy", r), 64'(rdy_q.size()), 64'(exp_ids.size()));
      for (int k = 0; k < rdy_q.size() && k < exp_ids.size(); k++)
        check($sformatf("rnd%0d_grant%0d", r, k), 64'(rdy_q[k]), 64'(exp_ids[k]));
      check($sformatf("rnd%0d_nwords", r), 64'(words.size()), 64'(exp_words.size()));
      for (int k = 0; k < words.size() && k < exp_words.size(); k++) begin
        e = exp_words[k];
        check($sformatf("rnd%0d_word%0d", r, k), words[k], e);
      end
      check_ge($sformatf("rnd%0d_gap", r), min_gap, GAP);
      check($sformatf("rnd%0d_badruns", r), 64'(bad_runs), 64'd0);
      check($sformatf("rnd%0d_gid", r), 64'(gid_bad), 64'd0);
      check($sformatf("rnd%0d_onehot", r), 64'(multi_rdy), 64'd0);
      for (int i = 0; i < NR; i++) q[i].delete();
      if (!tx_enable) tx_enable = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
